// File: rtl/main_cu.sv
// main_cu: job controller. It fetches a config word from memory, walks the
// R x C tile space in row-major order, hands tile index pairs to four
// processing units in batches of up to four, waits for each batch to finish,
// then writes a done status word back to memory.
module main_cu (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Data_Ready,
    input  logic        i_Grant,
    input  logic        i_Indexes_Received,
    input  logic        i_Result_Ready,
    inout  wire  [31:0] io_Memory_Data,
    output logic        o_Grant_Request,
    output logic [31:0] o_Config,
    output logic [9:0]  o_Memory_Address,
    output logic        o_Write_Enable,
    output logic [3:0]  o_Indexes_Ready,
    output logic [7:0]  o_Row_Index,
    output logic [7:0]  o_Column_Index
);

    // Explicit encodings so the state register can be observed and decoded
    // by checkers without depending on tool enum ordering.
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        REQUEST      = 3'd1,
        READ_CONFIG  = 3'd2,
        ISSUE        = 3'd3,
        WAIT_RESULT  = 3'd4,
        WRITE_STATUS = 3'd5,
        DONE         = 3'd6
    } state_t;

    localparam logic [31:0] STATUS_WORD    = 32'h8000_0000;
    localparam logic [9:0]  CONFIG_ADDR    = 10'd0;
    localparam logic [9:0]  STATUS_ADDR    = 10'd1;
    localparam logic [2:0]  BATCH_SIZE     = 3'd4;

    state_t      r_State;
    state_t      w_Next_State;

    logic [7:0]  r_Row;
    logic [7:0]  r_Column;
    logic [2:0]  r_Batch;
    logic        r_All_Issued;

    logic [7:0]  w_Next_Row;
    logic [7:0]  w_Next_Column;
    logic [2:0]  w_Next_Batch;
    logic        w_Next_All_Issued;
    logic [31:0] w_Next_Config;

    logic [7:0]  w_Rows;
    logic [7:0]  w_Columns;
    logic        w_Last_Column;
    logic        w_Last_Pair;
    logic        w_Empty_Job;
    logic [2:0]  w_Batch_Inc;

    // Tile counts come from the latched config; the empty-job test looks at
    // the bus directly because it is decided in the same cycle as the capture.
    assign w_Rows        = o_Config[7:0];
    assign w_Columns     = o_Config[15:8];
    assign w_Last_Column = (r_Column == (w_Columns - 8'd1));
    assign w_Last_Pair   = w_Last_Column && (r_Row == (w_Rows - 8'd1));
    assign w_Empty_Job   = (io_Memory_Data[7:0] == 8'd0) || (io_Memory_Data[15:8] == 8'd0);
    assign w_Batch_Inc   = r_Batch + 3'd1;

    // The status word is the only thing this block ever puts on the bus; it
    // releases the bus in every other cycle so memory can drive read data.
    assign io_Memory_Data = o_Write_Enable ? STATUS_WORD : 32'bz;

    // State, counter and config registers; reset aborts any job in flight.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State      <= IDLE;
            r_Row        <= 8'd0;
            r_Column     <= 8'd0;
            r_Batch      <= 3'd0;
            r_All_Issued <= 1'b0;
            o_Config     <= 32'd0;
        end else begin
            r_State      <= w_Next_State;
            r_Row        <= w_Next_Row;
            r_Column     <= w_Next_Column;
            r_Batch      <= w_Next_Batch;
            r_All_Issued <= w_Next_All_Issued;
            o_Config     <= w_Next_Config;
        end
    end

    // Next-state, counter updates and Moore/Mealy outputs.
    // Index handshake: o_Indexes_Ready is the valid, i_Indexes_Received is the
    // ready. A pair transfers on a rising edge where both are high; until then
    // the row, column and one-hot valid are held unchanged. The unit selected
    // is batch count mod 4.
    always_comb begin
        w_Next_State      = r_State;
        w_Next_Row        = r_Row;
        w_Next_Column     = r_Column;
        w_Next_Batch      = r_Batch;
        w_Next_All_Issued = r_All_Issued;
        w_Next_Config     = o_Config;

        o_Grant_Request   = 1'b0;
        o_Memory_Address  = CONFIG_ADDR;
        o_Write_Enable    = 1'b0;
        o_Indexes_Ready   = 4'b0000;
        o_Row_Index       = 8'd0;
        o_Column_Index    = 8'd0;

        case (r_State)
            IDLE: begin
                if (i_Data_Ready) begin
                    w_Next_State = REQUEST;
                end
            end

            REQUEST: begin
                o_Grant_Request = 1'b1;
                if (i_Grant) begin
                    w_Next_State = READ_CONFIG;
                end
            end

            READ_CONFIG: begin
                o_Grant_Request  = 1'b1;
                o_Memory_Address = CONFIG_ADDR;
                if (i_Grant) begin
                    w_Next_Config     = io_Memory_Data;
                    w_Next_Row        = 8'd0;
                    w_Next_Column     = 8'd0;
                    w_Next_Batch      = 3'd0;
                    w_Next_All_Issued = 1'b0;
                    // A job with no rows or no columns has nothing to issue.
                    w_Next_State      = w_Empty_Job ? WRITE_STATUS : ISSUE;
                end
            end

            ISSUE: begin
                o_Grant_Request = 1'b1;
                o_Indexes_Ready = 4'b0001 << r_Batch[1:0];
                o_Row_Index     = r_Row;
                o_Column_Index  = r_Column;
                if (i_Indexes_Received) begin
                    w_Next_Batch = w_Batch_Inc;
                    if (w_Last_Pair) begin
                        // Counters stay on the final pair; the flag records
                        // that the tile space is exhausted.
                        w_Next_All_Issued = 1'b1;
                        w_Next_State      = WAIT_RESULT;
                    end else begin
                        if (w_Last_Column) begin
                            w_Next_Column = 8'd0;
                            w_Next_Row    = r_Row + 8'd1;
                        end else begin
                            w_Next_Column = r_Column + 8'd1;
                        end
                        if (w_Batch_Inc == BATCH_SIZE) begin
                            w_Next_State = WAIT_RESULT;
                        end
                    end
                end
            end

            WAIT_RESULT: begin
                o_Grant_Request = 1'b1;
                if (i_Result_Ready) begin
                    w_Next_Batch = 3'd0;
                    w_Next_State = r_All_Issued ? WRITE_STATUS : ISSUE;
                end
            end

            WRITE_STATUS: begin
                o_Grant_Request  = 1'b1;
                o_Memory_Address = STATUS_ADDR;
                // The strobe only fires while the bus is granted, so exactly
                // one write happens on the edge that leaves this state.
                if (i_Grant) begin
                    o_Write_Enable = 1'b1;
                    w_Next_State   = DONE;
                end
            end

            DONE: begin
                if (!i_Data_Ready) begin
                    w_Next_State = IDLE;
                end
            end

            default: begin
                w_Next_State = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_main_cu.sv
// tb_main_cu: directed, table-driven bench for main_cu. A cycle table covers
// a full 3x3 job; hand-written sequences cover grant delay, handshake hold,
// empty job and asynchronous reset mid-job. Status writes are scored against
// an expected queue.
module tb_main_cu;

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_REQUEST      = 3'd1;
    localparam logic [2:0] S_READ_CONFIG  = 3'd2;
    localparam logic [2:0] S_ISSUE        = 3'd3;
    localparam logic [2:0] S_WAIT_RESULT  = 3'd4;
    localparam logic [2:0] S_WRITE_STATUS = 3'd5;
    localparam logic [2:0] S_DONE         = 3'd6;

    localparam logic [31:0] CFG_3X3  = 32'h0303_0303;
    localparam logic [31:0] CFG_2X1  = 32'h0000_0102;
    localparam logic [31:0] CFG_ZERO = 32'h0000_0003;
    localparam logic [31:0] DONE_WORD = 32'h8000_0000;

    // ---------------- clock / reset / DUT ----------------
    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Data_Ready = 1'b0;
    logic        i_Grant = 1'b0;
    logic        i_Indexes_Received = 1'b0;
    logic        i_Result_Ready = 1'b0;
    wire  [31:0] mem_bus;
    logic        o_Grant_Request;
    logic [31:0] o_Config;
    logic [9:0]  o_Memory_Address;
    logic        o_Write_Enable;
    logic [3:0]  o_Indexes_Ready;
    logic [7:0]  o_Row_Index;
    logic [7:0]  o_Column_Index;

    logic [31:0] mem_word = 32'd0;

    always #5 i_Clock = ~i_Clock;

    // Memory drives read data whenever the controller is not writing.
    assign mem_bus = o_Write_Enable ? 32'bz : mem_word;

    main_cu dut (
        .i_Clock            (i_Clock),
        .i_Reset            (i_Reset),
        .i_Data_Ready       (i_Data_Ready),
        .i_Grant            (i_Grant),
        .i_Indexes_Received (i_Indexes_Received),
        .i_Result_Ready     (i_Result_Ready),
        .io_Memory_Data     (mem_bus),
        .o_Grant_Request    (o_Grant_Request),
        .o_Config           (o_Config),
        .o_Memory_Address   (o_Memory_Address),
        .o_Write_Enable     (o_Write_Enable),
        .o_Indexes_Ready    (o_Indexes_Ready),
        .o_Row_Index        (o_Row_Index),
        .o_Column_Index     (o_Column_Index)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] snap();
        logic [2:0] st;
        st = dut.r_State;
        return {5'd0, st, o_Grant_Request, o_Memory_Address, o_Write_Enable,
                o_Indexes_Ready, o_Row_Index, o_Column_Index, o_Config};
    endfunction

    function automatic logic [71:0] expv(input logic [2:0] st, input logic greq,
                                         input logic [9:0] addr, input logic we,
                                         input logic [3:0] rdy, input logic [7:0] row,
                                         input logic [7:0] col, input logic [31:0] cfg);
        return {5'd0, st, greq, addr, we, rdy, row, col, cfg};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic dr, input logic g, input logic ir, input logic rr);
        i_Data_Ready       = dr;
        i_Grant            = g;
        i_Indexes_Received = ir;
        i_Result_Ready     = rr;
        #1;
    endtask

    // Scores any write strobed in this cycle, then advances to the next
    // falling edge (one rising edge in between).
    task automatic step();
        logic [31:0] e;
        if (o_Write_Enable) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         o_Memory_Address, mem_bus);
            end else begin
                e = exp_q.pop_front();
                check("status_write", {30'd0, o_Memory_Address, mem_bus}, {30'd0, 10'd1, e});
            end
        end
        @(negedge i_Clock);
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge i_Clock);
        i_Reset = 1'b0;
        #1;
        check("reset_state", snap(), expv(S_IDLE, 0, 10'd0, 0, 4'd0, 8'd0, 8'd0, 32'd0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        dr, g, ir, rr;
        logic [2:0]  st;
        logic        greq;
        logic [9:0]  addr;
        logic        we;
        logic [3:0]  rdy;
        logic [7:0]  row, col;
        logic [31:0] cfg;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic dr, input logic g, input logic ir, input logic rr,
                                input logic [2:0] st, input logic greq, input logic [9:0] addr,
                                input logic we, input logic [3:0] rdy, input logic [7:0] row,
                                input logic [7:0] col, input logic [31:0] cfg);
        vec_t v;
        v.dr = dr; v.g = g; v.ir = ir; v.rr = rr;
        v.st = st; v.greq = greq; v.addr = addr; v.we = we;
        v.rdy = rdy; v.row = row; v.col = col; v.cfg = cfg;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        logic [3:0] rdy_seen;
        bit reached;

        // Full 3x3 job, one row per cycle: inputs, then outputs seen before the edge.
        vecs[0]  = mk(1,1,0,0, S_IDLE,         0, 10'd0, 0, 4'h0, 8'd0, 8'd0, 32'd0);
        vecs[1]  = mk(1,1,0,0, S_REQUEST,      1, 10'd0, 0, 4'h0, 8'd0, 8'd0, 32'd0);
        vecs[2]  = mk(1,1,0,0, S_READ_CONFIG,  1, 10'd0, 0, 4'h0, 8'd0, 8'd0, 32'd0);
        vecs[3]  = mk(1,1,1,0, S_ISSUE,        1, 10'd0, 0, 4'h1, 8'd0, 8'd0, CFG_3X3);
        vecs[4]  = mk(1,1,1,1, S_ISSUE,        1, 10'd0, 0, 4'h2, 8'd0, 8'd1, CFG_3X3);
        vecs[5]  = mk(1,1,1,0, S_ISSUE,        1, 10'd0, 0, 4'h4, 8'd0, 8'd2, CFG_3X3);
        vecs[6]  = mk(1,1,1,0, S_ISSUE,        1, 10'd0, 0, 4'h8, 8'd1, 8'd0, CFG_3X3);
        vecs[7]  = mk(1,1,0,0, S_WAIT_RESULT,  1, 10'd0, 0, 4'h0, 8'd0, 8'd0, CFG_3X3);
        vecs[8]  = mk(1,1,0,1, S_WAIT_RESULT,  1, 10'd0, 0, 4'h0, 8'd0, 8'd0, CFG_3X3);
        vecs[9]  = mk(1,1,1,0, S_ISSUE,        1, 10'd0, 0, 4'h1, 8'd1, 8'd1, CFG_3X3);
        vecs[10] = mk(1,1,1,0, S_ISSUE,        1, 10'd0, 0, 4'h2, 8'd1, 8'd2, CFG_3X3);
        vecs[11] = mk(1,1,1,0, S_ISSUE,        1, 10'd0, 0, 4'h4, 8'd2, 8'd0, CFG_3X3);
        vecs[12] = mk(1,1,1,0, S_ISSUE,        1, 10'd0, 0, 4'h8, 8'd2, 8'd1, CFG_3X3);
        vecs[13] = mk(1,1,0,1, S_WAIT_RESULT,  1, 10'd0, 0, 4'h0, 8'd0, 8'd0, CFG_3X3);
        vecs[14] = mk(1,1,1,0, S_ISSUE,        1, 10'd0, 0, 4'h1, 8'd2, 8'd2, CFG_3X3);
        vecs[15] = mk(1,1,0,1, S_WAIT_RESULT,  1, 10'd0, 0, 4'h0, 8'd0, 8'd0, CFG_3X3);
        vecs[16] = mk(1,1,0,0, S_WRITE_STATUS, 1, 10'd1, 1, 4'h0, 8'd0, 8'd0, CFG_3X3);
        vecs[17] = mk(0,1,0,0, S_DONE,         0, 10'd0, 0, 4'h0, 8'd0, 8'd0, CFG_3X3);
        vecs[18] = mk(0,0,0,0, S_IDLE,         0, 10'd0, 0, 4'h0, 8'd0, 8'd0, CFG_3X3);

        @(negedge i_Clock);
        do_reset();

        mem_word = CFG_3X3;
        exp_q.push_back(DONE_WORD);
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].dr, vecs[i].g, vecs[i].ir, vecs[i].rr);
            check($sformatf("job3x3_vec%0d", i), snap(),
                  expv(vecs[i].st, vecs[i].greq, vecs[i].addr, vecs[i].we,
                       vecs[i].rdy, vecs[i].row, vecs[i].col, vecs[i].cfg));
            if (vecs[i].we)
                check("job3x3_bus", {40'd0, mem_bus}, {40'd0, DONE_WORD});
            step();
        end
        check("job3x3_writes", 72'(wr_count), 72'd1);

        // Grant delay: request held, nothing captured until grant arrives.
        do_reset();
        mem_word = CFG_2X1;
        drive(1, 0, 0, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0);
            check($sformatf("grant_wait%0d", k), snap(),
                  expv(S_REQUEST, 1, 10'd0, 0, 4'h0, 8'd0, 8'd0, 32'd0));
            step();
        end
        drive(1, 1, 0, 0);
        step();
        // Grant dropped in READ_CONFIG: capture waits for the next granted edge.
        drive(1, 0, 0, 0);
        check("rdcfg_nogrant", snap(), expv(S_READ_CONFIG, 1, 10'd0, 0, 4'h0, 8'd0, 8'd0, 32'd0));
        step();
        drive(1, 1, 0, 0);
        check("rdcfg_grant", snap(), expv(S_READ_CONFIG, 1, 10'd0, 0, 4'h0, 8'd0, 8'd0, 32'd0));
        step();

        // Handshake hold: pair and valid stay put while unacknowledged.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0);
            check($sformatf("hold%0d", k), snap(),
                  expv(S_ISSUE, 1, 10'd0, 0, 4'h1, 8'd0, 8'd0, CFG_2X1));
            step();
        end
        drive(1, 0, 1, 0);
        step();
        drive(1, 0, 0, 0);
        check("after_ack", snap(), expv(S_ISSUE, 1, 10'd0, 0, 4'h2, 8'd1, 8'd0, CFG_2X1));
        step();
        drive(1, 0, 1, 0);
        step();
        drive(1, 0, 0, 0);
        check("last_pair_wait", snap(), expv(S_WAIT_RESULT, 1, 10'd0, 0, 4'h0, 8'd0, 8'd0, CFG_2X1));
        step();
        drive(1, 0, 0, 1);
        step();
        exp_q.push_back(DONE_WORD);
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0);
            check($sformatf("status_nogrant%0d", k), snap(),
                  expv(S_WRITE_STATUS, 1, 10'd1, 0, 4'h0, 8'd0, 8'd0, CFG_2X1));
            step();
        end
        drive(1, 1, 0, 0);
        check("status_grant", snap(), expv(S_WRITE_STATUS, 1, 10'd1, 1, 4'h0, 8'd0, 8'd0, CFG_2X1));
        step();
        drive(1, 1, 0, 0);
        check("done_hold", snap(), expv(S_DONE, 0, 10'd0, 0, 4'h0, 8'd0, 8'd0, CFG_2X1));
        check("done_bus_released", {40'd0, mem_bus}, {40'd0, CFG_2X1});
        step();
        drive(0, 0, 0, 0);
        check("done_still", snap(), expv(S_DONE, 0, 10'd0, 0, 4'h0, 8'd0, 8'd0, CFG_2X1));
        step();
        drive(0, 0, 0, 0);
        check("idle_cfg_kept", snap(), expv(S_IDLE, 0, 10'd0, 0, 4'h0, 8'd0, 8'd0, CFG_2X1));
        check("grant_job_writes", 72'(wr_count), 72'd2);

        // Empty job: straight to the status write, no index valid ever raised.
        do_reset();
        mem_word = CFG_ZERO;
        exp_q.push_back(DONE_WORD);
        wr_before = wr_count;
        rdy_seen = 4'h0;
        reached = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(1, 1, 0, 0);
            if (dut.r_State == S_DONE) begin
                reached = 1'b1;
                break;
            end
            rdy_seen = rdy_seen | o_Indexes_Ready;
            step();
        end
        check("zero_reached_done", 72'(reached), 72'd1);
        check("zero_no_valid", 72'(rdy_seen), 72'd0);
        check("zero_one_write", 72'(wr_count - wr_before), 72'd1);
        check("zero_cfg", {40'd0, o_Config}, {40'd0, CFG_ZERO});
        step();
        drive(0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0);
        check("zero_idle", snap(), expv(S_IDLE, 0, 10'd0, 0, 4'h0, 8'd0, 8'd0, CFG_ZERO));

        // Asynchronous reset in ISSUE, between edges.
        do_reset();
        mem_word = CFG_3X3;
        wr_before = wr_count;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0);
            step();
        end
        drive(1, 1, 0, 0);
        check("pre_reset_issue", snap(), expv(S_ISSUE, 1, 10'd0, 0, 4'h1, 8'd0, 8'd0, CFG_3X3));
        #1;
        i_Reset = 1'b1;
        #1;
        check("async_reset", snap(), expv(S_IDLE, 0, 10'd0, 0, 4'h0, 8'd0, 8'd0, 32'd0));
        check("async_reset_bus", {40'd0, mem_bus}, {40'd0, CFG_3X3});
        i_Reset = 1'b0;
        i_Data_Ready = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 1);
            step();
        end
        drive(0, 0, 0, 0);
        check("abort_idle", snap(), expv(S_IDLE, 0, 10'd0, 0, 4'h0, 8'd0, 8'd0, 32'd0));
        check("abort_no_write", 72'(wr_count - wr_before), 72'd0);

        check("exp_q_empty", 72'(exp_q.size()), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
